// File: rtl/circular_pkg.sv
// rtl/circular_pkg.sv - shared types and defaults for the circular stepper
package circular_pkg;

  localparam int INT_BITS              = 16;
  localparam int DEF_DW_BOUND          = -180;
  localparam int DEF_UP_BOUND          = 179;
  localparam int DEF_RESET_VALUE       = 0;
  localparam int DEF_HOLD_DELAY        = 25_000_000;
  localparam int DEF_REPEAT_PERIOD     = 5_000_000;
  localparam int DEF_SEEK_PERIOD       = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_SEEK   = 2'd3
  } state_t;

  // Counter must hold the largest (period - 1); one spare bit keeps tiny periods legal.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/circular_step.sv
// rtl/circular_step.sv - wrapping prev/next neighbours of a bounded signed value
module circular_step
  import circular_pkg::*;
#(
  parameter int DATAW    = INT_BITS,
  parameter int DW_BOUND = DEF_DW_BOUND,
  parameter int UP_BOUND = DEF_UP_BOUND
) (
  input  logic signed [DATAW-1:0] value,
  output logic signed [DATAW-1:0] prev,
  output logic signed [DATAW-1:0] next
);

  localparam logic signed [DATAW-1:0] LO = DATAW'(DW_BOUND);
  localparam logic signed [DATAW-1:0] HI = DATAW'(UP_BOUND);

  assign next = (value == HI) ? LO : value + DATAW'(1);
  assign prev = (value == LO) ? HI : value - DATAW'(1);

endmodule

// File: rtl/circular_stepper.sv
// rtl/circular_stepper.sv - wrapping value driven by buttons or shortest-path seek
module circular_stepper
  import circular_pkg::*;
#(
  parameter int DATAW         = INT_BITS,
  parameter int DW_BOUND      = DEF_DW_BOUND,
  parameter int UP_BOUND      = DEF_UP_BOUND,
  parameter int RESET_VALUE   = DEF_RESET_VALUE,
  parameter int HOLD_DELAY    = DEF_HOLD_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int SEEK_PERIOD   = DEF_SEEK_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc_i,
  input  logic                    dec_i,
  input  logic                    seek_valid,
  output logic                    seek_ready,
  input  logic signed [DATAW-1:0] seek_target,
  output logic signed [DATAW-1:0] value_o,
  output logic                    step_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int CNTW = cnt_width(HOLD_DELAY, REPEAT_PERIOD, SEEK_PERIOD);
  localparam int WW   = DATAW + 2;

  localparam logic signed [DATAW-1:0] LO   = DATAW'(DW_BOUND);
  localparam logic signed [DATAW-1:0] HI   = DATAW'(UP_BOUND);
  localparam logic signed [DATAW-1:0] RSTV = DATAW'(RESET_VALUE);
  localparam logic signed [WW-1:0]    N_W    = WW'(UP_BOUND - DW_BOUND + 1);
  localparam logic signed [WW-1:0]    HALF_W = WW'((UP_BOUND - DW_BOUND + 1) / 2);
  localparam logic [CNTW-1:0] HOLD_LAST   = CNTW'(HOLD_DELAY - 1);
  localparam logic [CNTW-1:0] REPEAT_LAST = CNTW'(REPEAT_PERIOD - 1);
  localparam logic [CNTW-1:0] SEEK_LAST   = CNTW'(SEEK_PERIOD - 1);

  state_t                  state, state_next;
  logic [CNTW-1:0]         cnt, cnt_next;
  logic signed [DATAW-1:0] target, target_next, clamped;
  logic signed [DATAW-1:0] prev_v, next_v;
  logic signed [WW-1:0]    diff, fwd;
  logic                    dir_q, dir_next;
  logic                    press, dir, seek_up;
  logic                    do_step, step_up, done_next, held_lost;

  assign press      = inc_i ^ dec_i;
  assign dir        = inc_i;
  assign held_lost  = !press || (dir != dir_q);
  assign seek_ready = (state == ST_IDLE);

  circular_step #(
    .DATAW    (DATAW),
    .DW_BOUND (DW_BOUND),
    .UP_BOUND (UP_BOUND)
  ) u_step (
    .value (value_o),
    .prev  (prev_v),
    .next  (next_v)
  );

  // Clamp an incoming seek target into the legal range before latching it.
  always_comb begin
    clamped = seek_target;
    if (seek_target < LO)
      clamped = LO;
    else if (seek_target > HI)
      clamped = HI;
  end

  // Forward distance modulo N; at most half the ring (tie included) means go up.
  always_comb begin
    diff    = {{2{target[DATAW-1]}}, target} - {{2{value_o[DATAW-1]}}, value_o};
    fwd     = diff[WW-1] ? diff + N_W : diff;
    seek_up = (fwd <= HALF_W);
  end

  // State register plus all registered outputs and datapath state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      value_o <= RSTV;
      target  <= RSTV;
      cnt     <= '0;
      dir_q   <= 1'b0;
      step_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state  <= state_next;
      target <= target_next;
      cnt    <= cnt_next;
      dir_q  <= dir_next;
      if (do_step)
        value_o <= step_up ? next_v : prev_v;
      step_o <= do_step;
      busy_o <= (state_next != ST_IDLE);
      done_o <= done_next;
    end
  end

  // Next-state selection; a button press always pre-empts a seek.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (press)
          state_next = ST_HOLD;
        else if (seek_valid)
          state_next = ST_SEEK;
      end
      ST_HOLD: begin
        if (held_lost)
          state_next = ST_IDLE;
        else if (cnt == HOLD_LAST)
          state_next = ST_REPEAT;
      end
      ST_REPEAT: begin
        if (held_lost)
          state_next = ST_IDLE;
      end
      ST_SEEK: begin
        if (press)
          state_next = ST_HOLD;
        else if (value_o == target)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Step requests, counter, latched direction/target and done pulse per state.
  always_comb begin
    do_step     = 1'b0;
    step_up     = dir;
    cnt_next    = cnt;
    dir_next    = dir_q;
    target_next = target;
    done_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press) begin
          do_step  = 1'b1;
          step_up  = dir;
          dir_next = dir;
          cnt_next = '0;
        end else if (seek_valid) begin
          target_next = clamped;
          cnt_next    = '0;
        end
      end
      ST_HOLD: begin
        if (held_lost) begin
          cnt_next = '0;
        end else if (cnt == HOLD_LAST) begin
          do_step  = 1'b1;
          step_up  = dir_q;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNTW'(1);
        end
      end
      ST_REPEAT: begin
        if (held_lost) begin
          cnt_next = '0;
        end else if (cnt == REPEAT_LAST) begin
          do_step  = 1'b1;
          step_up  = dir_q;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNTW'(1);
        end
      end
      ST_SEEK: begin
        if (press) begin
          do_step  = 1'b1;
          step_up  = dir;
          dir_next = dir;
          cnt_next = '0;
        end else if (value_o == target) begin
          done_next = 1'b1;
          cnt_next  = '0;
        end else if (cnt == SEEK_LAST) begin
          do_step  = 1'b1;
          step_up  = seek_up;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNTW'(1);
        end
      end
      default: cnt_next = '0;
    endcase
  end

endmodule

// File: tb/tb_circular_stepper.sv
// tb/tb_circular_stepper.sv - directed self-checking bench for circular_stepper
module tb_circular_stepper;

  logic               clk = 1'b0;
  logic               reset;
  logic               inc_i;
  logic               dec_i;
  logic               seek_valid;
  logic               seek_ready;
  logic signed [15:0] seek_target;
  logic signed [15:0] value_o;
  logic               step_o;
  logic               busy_o;
  logic               done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  circular_stepper #(
    .DATAW         (16),
    .DW_BOUND      (-180),
    .UP_BOUND      (179),
    .RESET_VALUE   (0),
    .HOLD_DELAY    (4),
    .REPEAT_PERIOD (2),
    .SEEK_PERIOD   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inc_i       (inc_i),
    .dec_i       (dec_i),
    .seek_valid  (seek_valid),
    .seek_ready  (seek_ready),
    .seek_target (seek_target),
    .value_o     (value_o),
    .step_o      (step_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seek(input string tag, input logic signed [15:0] tgt,
                         input int exp_final, input int exp_steps, input int exp_first);
    int steps;
    int cyc;
    int first;
    steps = 0;
    cyc   = 0;
    first = 99999;
    seek_target = tgt;
    seek_valid  = 1'b1;
    tick();
    seek_valid = 1'b0;
    chk({tag, " accept busy"}, busy_o, 1);
    while (!done_o && cyc < 1000) begin
      tick();
      cyc++;
      if (step_o) begin
        steps++;
        if (steps == 1) first = value_o;
      end
    end
    chk({tag, " done"}, done_o, 1);
    chk({tag, " steps"}, steps, exp_steps);
    chk({tag, " first"}, first, exp_first);
    chk({tag, " final"}, value_o, exp_final);
    tick();
    chk({tag, " done once"}, done_o, 0);
    chk({tag, " idle"}, busy_o, 0);
  endtask

  int exp_v [12] = '{178, 178, 178, 178, 179, 179, -180, -180, -179, -179, -178, -178};
  int exp_s [12] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    reset       = 1'b1;
    inc_i       = 1'b0;
    dec_i       = 1'b0;
    seek_valid  = 1'b0;
    seek_target = '0;
    tick();
    tick();
    chk("rst value", value_o, 0);
    chk("rst step", step_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst ready", seek_ready, 1);
    reset = 1'b0;

    // single increment tap
    inc_i = 1'b1;
    tick();
    chk("tap value", value_o, 1);
    chk("tap step", step_o, 1);
    chk("tap busy", busy_o, 1);
    inc_i = 1'b0;
    tick();
    chk("tap release value", value_o, 1);
    chk("tap release step", step_o, 0);
    chk("tap release busy", busy_o, 0);
    chk("tap release ready", seek_ready, 1);

    do_seek("seek177", 16'sd177, 177, 176, 2);

    // hold to repeat across the wrap
    inc_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("hold value %0d", i), value_o, exp_v[i]);
      chk($sformatf("hold step %0d", i), step_o, exp_s[i]);
    end
    inc_i = 1'b0;
    tick();
    chk("hold release busy", busy_o, 0);
    chk("hold release value", value_o, -178);

    do_seek("seek-180", -16'sd180, -180, 2, -179);

    // decrement tap wraps low bound to high bound
    dec_i = 1'b1;
    tick();
    chk("dec wrap value", value_o, 179);
    chk("dec wrap step", step_o, 1);
    dec_i = 1'b0;
    tick();

    // both buttons held is not a press
    inc_i = 1'b1;
    dec_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("both step %0d", i), step_o, 0);
      chk($sformatf("both busy %0d", i), busy_o, 0);
    end
    chk("both value", value_o, 179);
    inc_i = 1'b0;
    dec_i = 1'b0;
    tick();

    do_seek("seek170", 16'sd170, 170, 9, 178);
    do_seek("seek-170 wrap", -16'sd170, -170, 20, 171);
    do_seek("seek0", 16'sd0, 0, 170, -169);
    do_seek("seek180 clamp", 16'sd180, 179, 179, 1);
    do_seek("seek0 down", 16'sd0, 0, 179, 178);
    do_seek("seek tie", -16'sd180, -180, 180, 1);
    do_seek("seek0 tie back", 16'sd0, 0, 180, -179);

    // press aborts a running seek
    seek_target = 16'sd100;
    seek_valid  = 1'b1;
    tick();
    seek_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort pre value", value_o, 3);
    inc_i = 1'b1;
    tick();
    chk("abort value", value_o, 4);
    chk("abort step", step_o, 1);
    chk("abort done", done_o, 0);
    chk("abort busy", busy_o, 1);
    tick();
    chk("abort hold value", value_o, 4);
    chk("abort hold done", done_o, 0);
    inc_i = 1'b0;
    tick();
    chk("abort release busy", busy_o, 0);
    chk("abort release done", done_o, 0);

    // reset in the middle of auto-repeat
    inc_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("repeat pre value", value_o, 6);
    reset = 1'b1;
    tick();
    chk("mid rst value", value_o, 0);
    chk("mid rst busy", busy_o, 0);
    chk("mid rst step", step_o, 0);
    chk("mid rst ready", seek_ready, 1);
    reset = 1'b0;
    inc_i = 1'b0;
    tick();

    // zero-distance seek finishes one cycle after accept
    seek_target = 16'sd0;
    seek_valid  = 1'b1;
    tick();
    seek_valid = 1'b0;
    chk("zero busy", busy_o, 1);
    chk("zero ready", seek_ready, 0);
    tick();
    chk("zero done", done_o, 1);
    chk("zero step", step_o, 0);
    chk("zero value", value_o, 0);
    chk("zero idle", busy_o, 0);
    tick();
    chk("zero done once", done_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
